pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, PC and address width.
REQ-002 SHALL have parameter STACK_DEPTH, default 4, number of return-stack entries.
REQ-003 SHALL have port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1, leave IDLE and begin fetching.
REQ-006 SHALL have port imem_req, output, 1, fetch request to instruction memory.
REQ-007 SHALL have port imem_ack, input, 1, memory accepted request and instruction is available.
REQ-008 SHALL have port imem_addr, output, ADDR_W, fetch address, always equal to pc.
REQ-009 SHALL have port instr_valid, output, 1, high for exactly the EXEC cycle.
REQ-010 SHALL have port branch_take, input, 1, take branch_target in EXEC.
REQ-011 SHALL have port branch_target, input, ADDR_W, jump or call destination.
REQ-012 SHALL have ports call and ret, input, 1 each, subroutine call and return in EXEC.
REQ-013 SHALL have port halt_in, input, 1, stop sequencing in EXEC.
REQ-014 SHALL have port pc, output, ADDR_W, current program counter.
REQ-015 SHALL have port tc, output, 1, high whenever pc equals all ones.
REQ-016 SHALL have port stack_err, output, 1, sticky return-stack overflow or underflow flag.
REQ-017 SHALL have port state, output, 2, IDLE=0, FETCH=1, EXEC=2, HALT=3.

Function
REQ-018 SHALL be in IDLE: pc held at 0, imem_req 0; start=1 moves it to FETCH on the next edge.
REQ-019 SHALL be in FETCH: imem_req=1 and imem_addr=pc; it stays in FETCH while imem_ack=0 and moves to EXEC on the edge where imem_ack=1.
REQ-020 SHALL spend exactly one cycle in EXEC, with instr_valid=1 and imem_req=0.
REQ-021 SHALL sample control inputs only in EXEC, with priority halt_in > ret > call > branch_take > increment.
REQ-022 SHALL, on halt_in in EXEC, go to HALT with pc unchanged; otherwise it returns to FETCH with the new pc loaded at the same edge.
REQ-023 SHALL, on increment, set pc to pc+1 modulo 2^ADDR_W, so all ones wraps to 0.
REQ-024 SHALL, on branch_take, set pc to branch_target.
REQ-025 SHALL, on call, push pc+1 (wrapped) onto the return stack and set pc to branch_target.
REQ-026 SHALL, on call with the stack full, drop the push, still take the jump, and set stack_err.
REQ-027 SHALL, on ret, pop the top of stack into pc; on ret with the stack empty, increment pc and set stack_err.
REQ-028 SHALL hold HALT until reset; start is ignored in HALT and EXEC.
REQ-029 SHALL derive tc combinationally from pc; it is valid in every state.
REQ-030 SHALL ignore imem_ack outside FETCH.

Reset
REQ-031 SHALL, on reset=1 at a clock edge, set: state IDLE, pc 0, stack empty, stack_err 0, imem_req 0, instr_valid 0, tc 0; this overrides any in-flight fetch or EXEC.
REQ-032 SHALL give reset priority over start and every other input.

Configuration
REQ-033 SHALL, with macro PC_SEQ_RET_STACK_EN defined, include the return stack and behave per REQ-025 to REQ-027.
REQ-034 SHALL, without PC_SEQ_RET_STACK_EN, omit the stack: call acts as branch_take with no push, ret acts as increment, and stack_err is tied to 0.

Verification
REQ-035 SHALL test: reset, then start, with imem_ack held 0 for 3 cycles then 1 -> 3 FETCH cycles with imem_addr=0, then EXEC, then pc=1 in FETCH.
REQ-036 SHALL test: 16 EXEC cycles with no control inputs (ADDR_W=4) -> pc goes 15 then 0; tc=1 only while pc=15.
REQ-037 SHALL test: pc=3, call with branch_target=9, then ret later -> pc 9, then pc 4 after the ret.
REQ-038 SHALL test: 5 nested calls (STACK_DEPTH=4) -> stack_err=1 after the 5th and stays 1; 4 rets restore the correct addresses.
REQ-039 SHALL test: halt_in=1 together with branch_take=1 in EXEC -> HALT, pc unchanged; start then ignored; reset -> IDLE, pc=0.
REQ-040 SHALL test: reset asserted mid-FETCH -> next cycle imem_req=0, state IDLE, stack_err=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: IDLE/FETCH/EXEC/HALT program-counter sequencer driving an instruction-memory handshake.
// Define PC_SEQ_RET_STACK_EN to build the call/return stack; without it call only jumps and ret only increments.
module pc_sequencer #(
   parameter int ADDR_W      = 4,
   parameter int STACK_DEPTH = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   output logic              imem_req,
   input  logic              imem_ack,
   output logic [ADDR_W-1:0] imem_addr,
   output logic              instr_valid,
   input  logic              branch_take,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic              call,
   input  logic              ret,
   input  logic              halt_in,
   output logic [ADDR_W-1:0] pc,
   output logic              tc,
   output logic              stack_err,
   output logic [1:0]        state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      ACT_NONE,
      ACT_HALT,
      ACT_RET,
      ACT_CALL,
      ACT_JUMP,
      ACT_INC
   } action_t;

   state_t            cur_state;
   state_t            nxt_state;
   action_t           action;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] pc_nxt;
   logic [ADDR_W-1:0] ret_addr;

   assign pc_inc = pc + ADDR_W'(1);

   // Control inputs are only looked at in EXEC, resolved in a fixed priority.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      action = ACT_NONE;
      if (cur_state == S_EXEC) begin
         if (halt_in)          action = ACT_HALT;
         else if (ret)         action = ACT_RET;
         else if (call)        action = ACT_CALL;
         else if (branch_take) action = ACT_JUMP;
         else                  action = ACT_INC;
      end
   end

   always_comb begin
      nxt_state = cur_state;
      case (cur_state)
         S_IDLE:  if (start) nxt_state = S_FETCH;
         S_FETCH: if (imem_ack) nxt_state = S_EXEC;
         S_EXEC:  nxt_state = (action == ACT_HALT) ? S_HALT : S_FETCH;
         S_HALT:  nxt_state = S_HALT;
         default: nxt_state = S_IDLE;
      endcase
   end

   always_comb begin
      pc_nxt = pc;
      case (action)
         ACT_RET:            pc_nxt = ret_addr;
         ACT_CALL, ACT_JUMP: pc_nxt = branch_target;
         ACT_INC:            pc_nxt = pc_inc;
         default:            pc_nxt = pc;
      endcase
   end

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         cur_state <= S_IDLE;
         pc        <= '0;
      end else begin
         cur_state <= nxt_state;
         pc        <= pc_nxt;
      end
   end

`ifdef PC_SEQ_RET_STACK_EN
   localparam int SP_W  = $clog2(STACK_DEPTH + 1);
   localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
   logic [SP_W-1:0]   sp;
   logic [IDX_W-1:0]  push_idx;
   logic [IDX_W-1:0]  top_idx;
   logic              stack_full;
   logic              stack_empty;
   logic              err_q;

   assign stack_full  = (sp == SP_W'(STACK_DEPTH));
   assign stack_empty = (sp == '0);
   assign push_idx    = IDX_W'(sp);
   assign top_idx     = IDX_W'(sp - SP_W'(1));

   // An empty-stack return falls through to the next instruction.
   assign ret_addr  = stack_empty ? pc_inc : stack_mem[top_idx];
   assign stack_err = err_q;

   // NOTE: the stack storage has no reset; sp == 0 already marks every entry invalid.
   always_ff @(posedge clock) begin
      if (action == ACT_CALL && !stack_full) begin
         stack_mem[push_idx] <= pc_inc;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sp    <= '0;
         err_q <= 1'b0;
      end else if (action == ACT_CALL) begin
         if (stack_full) err_q <= 1'b1;
         else            sp    <= sp + SP_W'(1);
      end else if (action == ACT_RET) begin
         if (stack_empty) err_q <= 1'b1;
         else             sp    <= sp - SP_W'(1);
      end
   end
`else
   assign ret_addr  = pc_inc;
   assign stack_err = 1'b0;
`endif

   assign imem_req    = (cur_state == S_FETCH);
   assign instr_valid = (cur_state == S_EXEC);
   assign imem_addr   = pc;
   assign tc          = &pc;
   assign state       = cur_state;

endmodule
